// File: rtl/jump_enc_pkg.sv
// Shared constants, result entry type and encode helper for the jump_encoder slice.
package jump_enc_pkg;

  localparam logic [5:0] OPC_J   = 6'h02;
  localparam logic [5:0] OPC_JAL = 6'h03;

  localparam int ERR_MIS = 0;
  localparam int ERR_REG = 1;

  localparam int REGION_HI = 31;
  localparam int REGION_LO = 28;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  err;
  } jenc_entry_t;

  // Erroring targets encode to a NOP so a bad patch never writes a live jump.
  function automatic jenc_entry_t jenc_encode(
    input logic [3:0]  pc_region,
    input logic [31:0] target,
    input logic [5:0]  opcode
  );
    jenc_entry_t e;
    e.err          = 2'b00;
    e.err[ERR_MIS] = (target[1:0] != 2'b00);
    e.err[ERR_REG] = (target[REGION_HI:REGION_LO] != pc_region);
    e.instr        = (e.err == 2'b00) ? {opcode, target[27:2]} : 32'h0000_0000;
    return e;
  endfunction

endpackage

// File: rtl/jump_enc_fifo.sv
// DEPTH-entry synchronous FIFO of encoded jump results.
// The read port holds the last popped entry while the FIFO is empty.
module jump_enc_fifo
  import jump_enc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  jenc_entry_t            wdata,
  output jenc_entry_t            rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  jenc_entry_t   mem [DEPTH];
  jenc_entry_t   hold_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? hold_q : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        hold_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jump_encoder.sv
// Packs absolute jump targets into J-type words, flagging misaligned or out-of-region targets.
// Defining JUMP_ENC_STATS_EN adds saturating good/error result counters cnt_ok and cnt_err.
module jump_encoder
  import jump_enc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_target,
  input  logic [5:0]  in_opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [1:0]  out_err,
  output logic        err_sticky,
  input  logic        clr_err
`ifdef JUMP_ENC_STATS_EN
  ,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic          ready_q;
  jenc_entry_t   enc;
  jenc_entry_t   head;
  logic          push;
  logic          pop;
  logic          push_err;
  logic          empty;
  logic          unused_full;
  logic [CW-1:0] count;
  logic          unused_pc_low;

  assign enc           = jenc_encode(in_pc[REGION_HI:REGION_LO], in_target, in_opcode);
  assign unused_pc_low = ^in_pc[REGION_LO-1:0];

  // ready_q keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign in_ready  = ready_q && (count < FULL_COUNT);
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push_err  = push && (enc.err != 2'b00);
  assign out_instr = head.instr;
  assign out_err   = head.err;

  jump_enc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (enc),
    .rdata (head),
    .full  (unused_full),
    .empty (empty),
    .count (count)
  );

  // A new error on the same edge as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (push_err) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef JUMP_ENC_STATS_EN
  logic push_ok;
  assign push_ok = push && (enc.err == 2'b00);

  // A clear restarts counting, so a push on the clearing edge is still counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok  <= 16'd0;
      cnt_err <= 16'd0;
    end else if (clr_err) begin
      cnt_ok  <= {15'd0, push_ok};
      cnt_err <= {15'd0, push_err};
    end else begin
      if (push_ok && (cnt_ok != 16'hFFFF)) begin
        cnt_ok <= cnt_ok + 16'd1;
      end
      if (push_err && (cnt_err != 16'hFFFF)) begin
        cnt_err <= cnt_err + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jump_encoder.sv
// Scoreboard bench for jump_encoder: expected results queued on accept, compared on pop.
module tb_jump_encoder;
  import jump_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic [5:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
  logic        err_sticky;
  logic        clr_err;
`ifdef JUMP_ENC_STATS_EN
  logic [15:0] cnt_ok;
  logic [15:0] cnt_err;
`endif

  int checks   = 0;
  int failures = 0;
  jenc_entry_t sb[$];
  jenc_entry_t mon_e;

  always #5 clk = ~clk;

  jump_encoder #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_target  (in_target),
    .in_opcode  (in_opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .clr_err    (clr_err)
`ifdef JUMP_ENC_STATS_EN
    ,
    .cnt_ok     (cnt_ok),
    .cnt_err    (cnt_err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  function automatic jenc_entry_t model(input logic [31:0] pc, input logic [31:0] target, input logic [5:0] opc);
    jenc_entry_t e;
    logic mis;
    logic rgn;
    mis     = (target[1:0] != 2'b00);
    rgn     = (target[31:28] != pc[31:28]);
    e.err   = {rgn, mis};
    e.instr = (mis || rgn) ? 32'h0 : {opc, target[27:2]};
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] target,
                               input logic [5:0] opc, input logic clr, output int waits);
    bit accepted;
    accepted  = 1'b0;
    waits     = 0;
    in_pc     = pc;
    in_target = target;
    in_opcode = opc;
    in_valid  = 1'b1;
    clr_err   = clr;
    for (int i = 0; i < 50 && !accepted; i++) begin
      accepted = in_ready;
      @(posedge clk);
      #1;
      if (!accepted) waits++;
    end
    in_valid = 1'b0;
    clr_err  = 1'b0;
    if (accepted) sb.push_back(model(pc, target, opc));
    else checkOutput("accept_timeout", 32'(waits), 32'd0);
  endtask

  task automatic drainOutputs();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("out_instr", out_instr, mon_e.instr);
        checkOutput("out_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] jaddr;
    jenc_entry_t ea;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_target = '0;
    in_opcode = '0;
    out_ready = 1'b0;
    clr_err   = 1'b0;

    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_sticky", 32'(err_sticky), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] basic encode");
    out_ready = 1'b1;
    pc = 32'h0040_0010;
    applyStimulus(pc, 32'h0040_0100, OPC_J, 1'b0, w);
    checkOutput("basic_latency_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_instr_const", out_instr, 32'h0810_0040);
    jaddr = {pc[31:28], out_instr[25:0], 2'b00};
    checkOutput("basic_jaddr_roundtrip", jaddr, 32'h0040_0100);
    @(posedge clk);
    #1;
    checkOutput("basic_empty_after_pop", 32'(out_valid), 32'd0);

    $display("[TB] misaligned target");
    applyStimulus(32'h0040_0010, 32'h0040_0102, OPC_J, 1'b0, w);
    checkOutput("mis_sticky_set", 32'(err_sticky), 32'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checkOutput("mis_sticky_cleared", 32'(err_sticky), 32'd0);

    $display("[TB] region mismatch");
    applyStimulus(32'h1000_0000, 32'h2000_0000, OPC_JAL, 1'b0, w);
    checkOutput("reg_sticky_set", 32'(err_sticky), 32'd1);
    applyStimulus(32'h1000_0000, 32'h2000_0003, OPC_JAL, 1'b1, w);
    checkOutput("reg_set_beats_clr", 32'(err_sticky), 32'd1);
    applyStimulus(32'h1000_0000, 32'h1000_0040, 6'h3F, 1'b1, w);
    checkOutput("good_push_with_clr", 32'(err_sticky), 32'd0);
    drainOutputs();

    $display("[TB] back-pressure");
    out_ready = 1'b0;
    ea = model(32'h0040_0000, 32'h0040_1000, OPC_J);
    applyStimulus(32'h0040_0000, 32'h0040_1000, OPC_J, 1'b0, w);
    checkOutput("bp_first_wait", 32'(w), 32'd0);
    applyStimulus(32'h0040_0000, 32'h0040_2000, OPC_JAL, 1'b0, w);
    checkOutput("bp_second_wait", 32'(w), 32'd0);
    checkOutput("bp_full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_head_held", out_instr, ea.instr);
    out_ready = 1'b1;
    #0;
    checkOutput("bp_full_no_pass", 32'(in_ready), 32'd0);
    applyStimulus(32'h0040_0000, 32'h0040_3000, OPC_J, 1'b0, w);
    checkOutput("bp_third_waits_one_pop", 32'(w), 32'd1);
    drainOutputs();

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) begin
      tgt = 32'h3000_0000 + 32'(i) * 32'h0000_1004 + ((i == 5) ? 32'd1 : 32'd0);
      applyStimulus(32'h3000_0000, tgt, (i % 2 == 1) ? OPC_JAL : OPC_J, 1'b0, w);
      checkOutput("stream_no_wait", 32'(w), 32'd0);
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
    end
    drainOutputs();

    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(32'h0040_0000, 32'h0040_0040, OPC_J, 1'b0, w);
    applyStimulus(32'h0040_0000, 32'h0040_0041, OPC_J, 1'b0, w);
    checkOutput("pre_reset_sticky", 32'(err_sticky), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("async_rst_sticky", 32'(err_sticky), 32'd0);
    checkOutput("async_rst_out_instr", out_instr, 32'd0);
`ifdef JUMP_ENC_STATS_EN
    checkOutput("async_rst_cnt_ok", 32'(cnt_ok), 32'd0);
    checkOutput("async_rst_cnt_err", 32'(cnt_err), 32'd0);
`endif
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("held_rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("no_stale_output", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    applyStimulus(32'h5000_0000, 32'h5ABC_DEF0, OPC_JAL, 1'b0, w);
    drainOutputs();

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jump_encoder.md
Name: jump_encoder

Overview:
- Inverse of jump-target formation: takes an absolute 32-bit jump target plus the current PC and packs a J-type instruction word {opcode[5:0], target[27:2]}.
- Checks that the target can be reached: it must be word-aligned and in the same 256 MB region as the PC.
- Used by the boot loader / debug patch path to write jump instructions into instruction memory.
- Valid/ready handshake on both sides; results are buffered in a small output FIFO.

Parameters:
- DEPTH, 2, number of output FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_pc  in  32  PC whose bits [31:28] give the jump region
- in_target  in  32  absolute jump destination
- in_opcode  in  6  J-type opcode (J or JAL)
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_err  out  2  bit0 = misaligned, bit1 = region mismatch
- err_sticky  out  1  set by any error result; held until cleared
- clr_err  in  1  synchronous clear of err_sticky

Behaviour:
- Reset (asynchronous on rst_n low):
  - FIFO emptied; out_valid=0, out_instr=0, out_err=0, err_sticky=0.
  - in_ready=0 while rst_n is low, and 1 from the first edge after release.
  - An in-flight request or unpopped output at reset is discarded, not replayed.
- Encode (combinational on input, registered into FIFO):
  - mis = (in_target[1:0] != 0)
  - reg = (in_target[31:28] != in_pc[31:28])
  - If no error: instr = {in_opcode, in_target[27:2]}. Otherwise instr = 32'h0000_0000 (NOP) and err = {reg, mis}.
  - An erroring request is still pushed; it is never dropped silently.
- in_ready = (count < DEPTH).
  - No pass-through when full: in_ready stays low when count==DEPTH, even if out_ready=1 that cycle.
- Latency: a request accepted at edge N gives out_valid=1 after edge N if the FIFO was empty. FIFO order is preserved.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, pointers wrap modulo DEPTH.
- Pop of the last entry with no push: out_valid falls after that edge. out_instr/out_err hold their last value but are don't-care while out_valid=0.
- out_valid && !out_ready: out_instr/out_err stay stable until the pop.
- err_sticky: set on the edge that pushes an error. clr_err clears it. If both happen on the same edge, set wins.
- in_opcode is not checked; an opcode outside J/JAL passes through unchanged.

Optional Feature:
- Macro: JUMP_ENC_STATS_EN
- Defined:
  - Adds outputs cnt_ok[15:0] and cnt_err[15:0]. They count pushed good results and pushed error results.
  - Both saturate at 16'hFFFF, reset to 0, and are also cleared by clr_err.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package jump_enc_pkg:
  - OPC_J=6'h02, OPC_JAL=6'h03
  - ERR_MIS=0, ERR_REG=1 (bit indices)
  - REGION_HI=31, REGION_LO=28
  - typedef jenc_entry_t {instr[31:0], err[1:0]}
- Sub-module jump_enc_fifo: parameterised DEPTH-entry synchronous FIFO of jenc_entry_t, with push/pop/full/empty/count.
- The top level holds the encode logic, the sticky flag and the optional counters.

Test Plan:
- Basic encode: pc=0x0040_0010, target=0x0040_0100, opcode=0x02, out_ready=1 -> out_instr=0x0810_0040, err=00, out_valid one cycle after accept. Feeding in_target[27:2] back through jump-address formation with this pc gives 0x0040_0100.
- Misaligned target: target=0x0040_0102 -> out_instr=0x0000_0000, err=01, err_sticky=1. Pulse clr_err -> err_sticky=0.
- Region mismatch: pc=0x1000_0000, target=0x2000_0000, opcode=0x03 -> out_instr=0, err=10. A second error pushed on the same edge as clr_err leaves err_sticky=1.
- Back-pressure: out_ready=0, push 3 requests -> in_ready=0 after 2 accepts. Raise out_ready -> outputs arrive in order, third request accepted only after the first pop. With count==DEPTH and out_ready=1, in_ready is still 0 that cycle.
- Streaming: out_ready=1 and 8 back-to-back requests -> push and pop every cycle, count stays 1, no loss across pointer wrap.
- Reset mid-operation: FIFO holding 2 entries, assert rst_n=0 asynchronously -> out_valid=0 immediately. After release, no stale output appears. With JUMP_ENC_STATS_EN defined, the counters read 0.
